wb_write_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two sources:
  - the pipeline writeback stage (MEM/WB register outputs);
  - a long-latency multiply/divide unit (MDU).
- Performs the ALU/memory writeback select for the pipeline source.
- Parks a losing MDU result in a one-entry holding slot.
- Forces a one-cycle pipeline stall when that result has waited MAX_WAIT cycles.
- Sits between the MEM/WB register, the MDU and the register file write port.

---
 rtl/wb_write_arbiter_if.sv | 53 +++++
 rtl/wb_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  wb_write_arbiter_if
//  Bundles the writeback, MDU and register-file write-port signals of the
//  write arbiter. STALL_COUNT_EN adds the forced-stall counter output.
//  Revision: 1.0
// ============================================================================
interface wb_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wb_we;
   logic              wb_memtoreg;
   logic [DATA_W-1:0] wb_alu;
   logic [DATA_W-1:0] wb_mem;
   logic [ADDR_W-1:0] wb_dest;
   logic              mdu_valid;
   logic [DATA_W-1:0] mdu_data;
   logic [ADDR_W-1:0] mdu_dest;
   logic              mdu_ready;
   logic              stall_pipe;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
`ifdef STALL_COUNT_EN
   logic [15:0]       stall_count;

   modport slave (
      input  wb_we, wb_memtoreg, wb_alu, wb_mem, wb_dest,
      input  mdu_valid, mdu_data, mdu_dest,
      output mdu_ready, stall_pipe, rf_we, rf_addr, rf_data, stall_count
   );

   modport master (
      output wb_we, wb_memtoreg, wb_alu, wb_mem, wb_dest,
      output mdu_valid, mdu_data, mdu_dest,
      input  mdu_ready, stall_pipe, rf_we, rf_addr, rf_data, stall_count
   );
`else
   modport slave (
      input  wb_we, wb_memtoreg, wb_alu, wb_mem, wb_dest,
      input  mdu_valid, mdu_data, mdu_dest,
      output mdu_ready, stall_pipe, rf_we, rf_addr, rf_data
   );

   modport master (
      output wb_we, wb_memtoreg, wb_alu, wb_mem, wb_dest,
      output mdu_valid, mdu_data, mdu_dest,
      input  mdu_ready, stall_pipe, rf_we, rf_addr, rf_data
   );
`endif
endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  wb_write_arbiter
//  Shares the register-file write port between the MEM/WB stage and the MDU,
//  parking a losing MDU result and forcing a one-cycle stall after MAX_WAIT
//  losses. Optional macro STALL_COUNT_EN adds a saturating FORCE-cycle count.
//  Revision: 1.0
// ============================================================================
module wb_write_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic            Clock,
   input  logic            Reset,
   wb_write_arbiter_if.slave bus
);

   localparam logic [3:0] c_WAIT_LAST = 4'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FORCE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_wait_cnt;
   logic [3:0]        w_wait_cnt_nxt;
   logic [ADDR_W-1:0] r_slot_dest;
   logic [DATA_W-1:0] r_slot_data;
   logic              r_rf_we;
   logic [ADDR_W-1:0] r_rf_addr;
   logic [DATA_W-1:0] r_rf_data;

   logic              w_stall;
   logic              w_ready;
   logic              w_pw;
   logic              w_mdu_live;
   logic              w_capture;
   logic              w_grant;
   logic [ADDR_W-1:0] w_gaddr;
   logic [DATA_W-1:0] w_gdata;
   logic [DATA_W-1:0] w_pipe_data;

   assign w_stall     = (r_state == ST_FORCE);
   assign w_ready     = (r_state == ST_IDLE);
   assign w_pw        = bus.wb_we && (bus.wb_dest != '0) && !w_stall;
   assign w_pipe_data = bus.wb_memtoreg ? bus.wb_mem : bus.wb_alu;
   // A zero-destination MDU transfer is still accepted; it just never lands.
   assign w_mdu_live  = bus.mdu_valid && w_ready && (bus.mdu_dest != '0);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_capture      = 1'b0;
      w_grant        = 1'b0;
      w_gaddr        = '0;
      w_gdata        = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_pw) begin
               w_grant = 1'b1;
               w_gaddr = bus.wb_dest;
               w_gdata = w_pipe_data;
               if (w_mdu_live) begin
                  w_capture      = 1'b1;
                  w_wait_cnt_nxt = 4'd0;
                  w_state_nxt    = ST_HOLD;
               end
            end else if (w_mdu_live) begin
               w_grant = 1'b1;
               w_gaddr = bus.mdu_dest;
               w_gdata = bus.mdu_data;
            end
         end
         ST_HOLD: begin
            w_grant = 1'b1;
            if (w_pw) begin
               w_gaddr        = bus.wb_dest;
               w_gdata        = w_pipe_data;
               w_wait_cnt_nxt = r_wait_cnt + 4'd1;
               if (r_wait_cnt == c_WAIT_LAST) begin
                  w_state_nxt = ST_FORCE;
               end
            end else begin
               w_gaddr     = r_slot_dest;
               w_gdata     = r_slot_data;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FORCE: begin
            // MEM/WB is frozen this cycle, so the pipeline write is replayed.
            w_grant     = 1'b1;
            w_gaddr     = r_slot_dest;
            w_gdata     = r_slot_data;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_slot_dest <= '0;
         r_slot_data <= '0;
      end else if (w_capture) begin
         r_slot_dest <= bus.mdu_dest;
         r_slot_data <= bus.mdu_data;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_rf_we   <= 1'b0;
         r_rf_addr <= '0;
         r_rf_data <= '0;
      end else begin
         r_rf_we <= w_grant;
         if (w_grant) begin
            r_rf_addr <= w_gaddr;
            r_rf_data <= w_gdata;
         end
      end
   end

   assign bus.mdu_ready  = w_ready;
   assign bus.stall_pipe = w_stall;
   assign bus.rf_we      = r_rf_we;
   assign bus.rf_addr    = r_rf_addr;
   assign bus.rf_data    = r_rf_data;

`ifdef STALL_COUNT_EN
   logic [15:0] r_stall_count;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_stall_count <= 16'd0;
      end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

   assign bus.stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_wb_write_arbiter
//  Directed self-checking bench for wb_write_arbiter (MAX_WAIT = 4).
//  Revision: 1.0
// ============================================================================
module tb_wb_write_arbiter;

   logic Clock;
   logic Reset;
   int   vectors;
   int   errors;

   wb_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   wb_write_arbiter #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .MAX_WAIT (4)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wb_we       = 1'b0;
      bus.wb_memtoreg = 1'b0;
      bus.wb_alu      = 32'h0;
      bus.wb_mem      = 32'h0;
      bus.wb_dest     = 5'd0;
      bus.mdu_valid   = 1'b0;
      bus.mdu_data    = 32'h0;
      bus.mdu_dest    = 5'd0;
   endtask

   task automatic pipe(input logic [4:0] dest, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] mem);
      bus.wb_we       = 1'b1;
      bus.wb_dest     = dest;
      bus.wb_memtoreg = m2r;
      bus.wb_alu      = alu;
      bus.wb_mem      = mem;
   endtask

   task automatic mdu(input logic [4:0] dest, input logic [31:0] data);
      bus.mdu_valid = 1'b1;
      bus.mdu_dest  = dest;
      bus.mdu_data  = data;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
      chk({tag, ".we"},   32'(bus.rf_we), 32'd1);
      chk({tag, ".addr"}, 32'(bus.rf_addr), 32'(addr));
      chk({tag, ".data"}, bus.rf_data, data);
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      Reset   = 1'b1;
      idle_inputs();
      step();
      step();

      // Reset state
      chk("rst.we",    32'(bus.rf_we), 32'd0);
      chk("rst.addr",  32'(bus.rf_addr), 32'd0);
      chk("rst.data",  bus.rf_data, 32'd0);
      chk("rst.ready", 32'(bus.mdu_ready), 32'd1);
      chk("rst.stall", 32'(bus.stall_pipe), 32'd0);
      Reset = 1'b0;
      step();
      chk("post_rst.we", 32'(bus.rf_we), 32'd0);

      // Pipeline-only writes: memory select then ALU select
      pipe(5'd3, 1'b1, 32'h11111111, 32'hCAFEF00D);
      step();
      chk_wr("pipe_mem", 5'd3, 32'hCAFEF00D);
      pipe(5'd2, 1'b0, 32'h11111111, 32'hCAFEF00D);
      step();
      chk_wr("pipe_alu", 5'd2, 32'h11111111);
      idle_inputs();
      step();
      chk("nogrant.we",   32'(bus.rf_we), 32'd0);
      chk("nogrant.addr", 32'(bus.rf_addr), 32'd2);
      chk("nogrant.data", bus.rf_data, 32'h11111111);

      // MDU alone goes straight through
      mdu(5'd9, 32'hDEAD0001);
      chk("mdu_only.ready_pre", 32'(bus.mdu_ready), 32'd1);
      step();
      chk_wr("mdu_only", 5'd9, 32'hDEAD0001);
      chk("mdu_only.ready", 32'(bus.mdu_ready), 32'd1);
      idle_inputs();
      step();

      // Collision then gap: r4 at N+1, r5 at N+2
      pipe(5'd4, 1'b0, 32'h00000044, 32'h0);
      mdu(5'd5, 32'h00000055);
      step();
      chk_wr("coll.pipe", 5'd4, 32'h00000044);
      chk("coll.ready_hold", 32'(bus.mdu_ready), 32'd0);
      chk("coll.stall_hold", 32'(bus.stall_pipe), 32'd0);
      idle_inputs();
      step();
      chk_wr("coll.mdu", 5'd5, 32'h00000055);
      chk("coll.ready_back", 32'(bus.mdu_ready), 32'd1);
      step();
      chk("coll.quiet", 32'(bus.rf_we), 32'd0);

      // Starvation: r6 held through 4 lost cycles, then forced
      pipe(5'd10, 1'b0, 32'h000000A0, 32'h0);
      mdu(5'd6, 32'h00000066);
      step();
      chk_wr("starve.c0", 5'd10, 32'h000000A0);
      bus.mdu_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         pipe(5'(10 + k), 1'b0, 32'(32'hA0 + k), 32'h0);
         step();
         chk_wr($sformatf("starve.p%0d", k), 5'(10 + k), 32'(32'hA0 + k));
         chk($sformatf("starve.stall%0d", k), 32'(bus.stall_pipe), (k == 4) ? 32'd1 : 32'd0);
         chk($sformatf("starve.ready%0d", k), 32'(bus.mdu_ready), 32'd0);
      end
      pipe(5'd15, 1'b0, 32'h000000A5, 32'h0);
      step();
      chk_wr("starve.force", 5'd6, 32'h00000066);
      chk("starve.stall_off", 32'(bus.stall_pipe), 32'd0);
      chk("starve.ready_back", 32'(bus.mdu_ready), 32'd1);
      step();
      chk_wr("starve.replay", 5'd15, 32'h000000A5);
      idle_inputs();
      step();

      // Zero destinations: nothing written, MDU transfer still accepted
      pipe(5'd0, 1'b1, 32'h0, 32'h77777777);
      mdu(5'd0, 32'h88888888);
      step();
      chk("zero.we",    32'(bus.rf_we), 32'd0);
      chk("zero.ready", 32'(bus.mdu_ready), 32'd1);
      chk("zero.stall", 32'(bus.stall_pipe), 32'd0);
      step();
      chk("zero.we2",    32'(bus.rf_we), 32'd0);
      chk("zero.ready2", 32'(bus.mdu_ready), 32'd1);
      idle_inputs();
      step();

      // Reset during HOLD: held r7 result is lost
      pipe(5'd8, 1'b0, 32'h00000088, 32'h0);
      mdu(5'd7, 32'h00001234);
      step();
      chk("rhold.ready_hold", 32'(bus.mdu_ready), 32'd0);
      idle_inputs();
      #2;
      Reset = 1'b1;
      #1;
      chk("rhold.we",    32'(bus.rf_we), 32'd0);
      chk("rhold.addr",  32'(bus.rf_addr), 32'd0);
      chk("rhold.ready", 32'(bus.mdu_ready), 32'd1);
      chk("rhold.stall", 32'(bus.stall_pipe), 32'd0);
      step();
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("rhold.after_we%0d", k), 32'(bus.rf_we), 32'd0);
         chk($sformatf("rhold.after_ready%0d", k), 32'(bus.mdu_ready), 32'd1);
         chk($sformatf("rhold.after_addr%0d", k), 32'(bus.rf_addr), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
